multi_cycle_control: RTL

- Moore-style main control FSM for the multi-cycle MIPS datapath, which replaces the single-cycle datapath and shares one memory and one ALU across cycles.
- Supports the same instruction set as the single-cycle design: add, sub, and, or, slt, lw, sw, beq.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, driving every datapath mux and write-enable.
- Stalls on a memory-ready handshake, flags illegal opcodes, and counts retired instructions.

---
 rtl/mips_ctrl_pkg.sv | 49 ++++
 rtl/multi_cycle_control_if.sv | 40 ++++
 rtl/multi_cycle_control.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path.
// The main control FSM, the ALU-control block and the datapath all use this
// package, so the encodings below have to stay in step with all of them.
package mips_ctrl_pkg;

    // Opcodes, taken from instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    // Main control states; the debug port exposes these exact values
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ILLEGAL   = 4'd10
    } state_t;

    // ALU operation requests handed to the ALU-control block
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALUSRCB_REG     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Loads and stores share the address-calculation state
    function automatic logic isMemOp(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Bundle of signals between the main control FSM and the multi-cycle datapath.
// master: the controller (drives the control lines, reads opcode/mem_ready).
// slave:  the datapath side (supplies opcode/mem_ready, consumes controls).
interface multi_cycle_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_source;
    logic [3:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal, retired
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal, retired
    );

endinterface

// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath (add, sub, and, or, slt,
// lw, sw, beq and optionally j). Moore outputs per state, except that FETCH
// gates ir_write/pc_write with mem_ready so a stalled fetch writes nothing.
// Also keeps a sticky illegal-opcode flag and a retired-instruction counter.
// Optional feature: define MULTI_CYCLE_CONTROL_JUMP_EN to decode opcode 0x02
// as a jump; without it the JUMP state does not exist and 0x02 is illegal.
module multi_cycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int         CNT_W    = 32,
    parameter logic [5:0] RTYPE_OP = OP_RTYPE
) (
    input  logic                  clock,
    input  logic                  clear,
    multi_cycle_control_if.master bus
);

    state_t           stateQ;
    state_t           nextState;
    logic             retireNow;
    logic             illegalQ;
    logic [CNT_W-1:0] retiredCnt;

    assign bus.state   = stateQ;
    assign bus.illegal = illegalQ;
    assign bus.retired = retiredCnt;

    // State register, sticky illegal flag and retire counter; clear abandons any in-flight instruction
    always_ff @(posedge clock) begin
        if (clear) begin
            stateQ     <= S_FETCH;
            retiredCnt <= '0;
            illegalQ   <= 1'b0;
        end else begin
            stateQ <= nextState;
            if (retireNow) begin
                retiredCnt <= retiredCnt + CNT_W'(1);
            end
            if (stateQ == S_ILLEGAL) begin
                illegalQ <= 1'b1;
            end
        end
    end

    // Next-state, retire detection and control-line decode for the current state
    always_comb begin
        nextState         = S_FETCH;
        retireNow         = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = ALUSRCB_REG;
        bus.alu_op        = ALUOP_ADD;
        bus.pc_source     = PCSRC_ALU;

        case (stateQ)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = ALUSRCB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                nextState     = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.alu_src_b = ALUSRCB_IMM_SH2;
                if (bus.opcode == RTYPE_OP) begin
                    nextState = S_EXECUTE;
                end else if (isMemOp(bus.opcode)) begin
                    nextState = S_MEM_ADDR;
                end else if (bus.opcode == OP_BEQ) begin
                    nextState = S_BRANCH;
`ifdef MULTI_CYCLE_CONTROL_JUMP_EN
                end else if (bus.opcode == OP_J) begin
                    nextState = S_JUMP;
`endif
                end else begin
                    nextState = S_ILLEGAL;
                end
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ALUSRCB_IMM;
                nextState     = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
                nextState    = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
            end
            S_MEM_WB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                retireNow      = 1'b1;
            end
            S_MEM_WRITE: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
                nextState     = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
                retireNow     = bus.mem_ready;
            end
            S_EXECUTE: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_FUNCT;
                nextState     = S_ALU_WB;
            end
            S_ALU_WB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = 1'b1;
                retireNow     = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALUOP_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCSRC_ALUOUT;
                retireNow         = 1'b1;
            end
`ifdef MULTI_CYCLE_CONTROL_JUMP_EN
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCSRC_JUMP;
                retireNow     = 1'b1;
            end
`endif
            S_ILLEGAL: begin
                nextState = S_FETCH;
            end
            default: begin
                nextState = S_FETCH;
            end
        endcase

        if (clear) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.ir_write      = 1'b0;
            bus.reg_write     = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
        end
    end

endmodule
